// File: rtl/cic_interpolator_pkg.sv
// ============================================================================
// Module      : cic_interpolator_pkg
// Description : Shared CIC constants and width helpers (interpolator/decimator)
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cic_interpolator_pkg;

  localparam int CIC_ORDER = 2;

  // Bit growth of an order-2 CIC with ratio osr, shared with the decimator.
  function automatic int cic_w(input int bit_w, input int osr);
    return bit_w + CIC_ORDER * $clog2(osr);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_interpolator_integrator2.sv
// ============================================================================
// Module      : cic_integrator2
// Description : Two cascaded W-bit modular accumulators, sync active-low clear
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cic_integrator2
  import cic_interpolator_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_u,
  output logic [W-1:0] o_i2
);

  logic [W-1:0] r_i1;
  logic [W-1:0] r_i2;

  // Second stage accumulates the pre-edge value of the first stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i1 <= '0;
      r_i2 <= '0;
    end else begin
      r_i1 <= r_i1 + i_u;
      r_i2 <= r_i2 + r_i1;
    end
  end

  assign o_i2 = r_i2;

endmodule

`default_nettype wire

// File: rtl/cic_interpolator.sv
// ============================================================================
// Module      : cic_interpolator
// Description : 2nd-order CIC interpolator: low-rate combs, zero-stuff, full-rate integrators
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cic_interpolator
  import cic_interpolator_pkg::*;
#(
  parameter int OSR       = 64,
  parameter int BIT       = 12,
  parameter int SIGNED_IN = 1,
  parameter int CNT_W     = 8
) (
  input  logic                      FADC,
  input  logic                      RST_SN,
  input  logic [BIT-1:0]            IN_DATA,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [cic_w(BIT,OSR)-1:0] OUT_DATA,
  output logic                      OUT_VALID,
  output logic                      UNDERRUN,
  output logic [CNT_W-1:0]          UNDERRUN_CNT
);

  localparam int W    = cic_w(BIT, OSR);
  localparam int PH_W = $clog2(OSR);

  generate
    if (!is_pow2(OSR)) begin : g_osr_check
      $error("cic_interpolator: OSR must be a power of 2 and at least 2");
    end
  endgenerate

  logic [PH_W-1:0]  r_ph;
  logic [W-1:0]     r_x;
  logic [W-1:0]     r_c1;
  logic [W-1:0]     r_c2;
  logic             r_out_valid;
  logic             r_underrun;
  logic [CNT_W-1:0] r_ucnt;

  logic [W-1:0]     w_x_ext;
  logic [W-1:0]     w_x_new;
  logic [W-1:0]     w_c1_new;
  logic [W-1:0]     w_u;
  logic             w_phase0;

  generate
    if (SIGNED_IN != 0) begin : g_ext_signed
      assign w_x_ext = {{(W-BIT){IN_DATA[BIT-1]}}, IN_DATA};
    end else begin : g_ext_unsigned
      assign w_x_ext = {{(W-BIT){1'b0}}, IN_DATA};
    end
  endgenerate

  assign w_phase0 = (r_ph == '0);
  assign IN_READY = w_phase0;

  // An underrun repeats the held sample, so the first comb sees zero change.
  assign w_x_new  = IN_VALID ? w_x_ext : r_x;
  assign w_c1_new = w_x_new - r_x;

  assign w_u = (r_ph == PH_W'(1)) ? r_c2 : '0;

  always_ff @(posedge FADC) begin
    if (!RST_SN) begin
      r_ph        <= '0;
      r_x         <= '0;
      r_c1        <= '0;
      r_c2        <= '0;
      r_out_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_ucnt      <= '0;
    end else begin
      r_ph       <= r_ph + PH_W'(1);
      r_underrun <= w_phase0 & ~IN_VALID;
      if (w_phase0) begin
        r_x  <= w_x_new;
        r_c1 <= w_c1_new;
        r_c2 <= w_c1_new - r_c1;
        if (IN_VALID) begin
          r_out_valid <= 1'b1;
        end else if (r_ucnt != '1) begin
          r_ucnt <= r_ucnt + CNT_W'(1);
        end
      end
    end
  end

  cic_integrator2 #(
    .W (W)
  ) u_integ (
    .clk   (FADC),
    .rst_n (RST_SN),
    .i_u   (w_u),
    .o_i2  (OUT_DATA)
  );

  assign OUT_VALID    = r_out_valid;
  assign UNDERRUN     = r_underrun;
  assign UNDERRUN_CNT = r_ucnt;

endmodule

`default_nettype wire

// File: tb/tb_cic_interpolator.sv
// ============================================================================
// Module      : tb_cic_interpolator
// Description : Directed bench for cic_interpolator (OSR=4 signed, OSR=64 unsigned)
// Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_cic_interpolator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // OSR=4, BIT=12, signed, W=16, small counter to reach saturation quickly
  logic        rst4_n;
  logic [11:0] din4;
  logic        vin4;
  logic        rdy4;
  logic [15:0] out4;
  logic        ov4;
  logic        ur4;
  logic [2:0]  cnt4;

  // OSR=64, BIT=12, unsigned, W=24
  logic        rst64_n;
  logic [11:0] din64;
  logic        vin64;
  logic        rdy64;
  logic [23:0] out64;
  logic        ov64;
  logic        ur64;
  logic [7:0]  cnt64;

  cic_interpolator #(.OSR(4), .BIT(12), .SIGNED_IN(1), .CNT_W(3)) u_dut4 (
    .FADC(clk), .RST_SN(rst4_n), .IN_DATA(din4), .IN_VALID(vin4), .IN_READY(rdy4),
    .OUT_DATA(out4), .OUT_VALID(ov4), .UNDERRUN(ur4), .UNDERRUN_CNT(cnt4)
  );

  cic_interpolator #(.OSR(64), .BIT(12), .SIGNED_IN(0), .CNT_W(8)) u_dut64 (
    .FADC(clk), .RST_SN(rst64_n), .IN_DATA(din64), .IN_VALID(vin64), .IN_READY(rdy64),
    .OUT_DATA(out64), .OUT_VALID(ov64), .UNDERRUN(ur64), .UNDERRUN_CNT(cnt64)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts at phase 0; after edge t+k the output is a_ext * min(k-1, 4).
  task automatic step4(input string tag, input logic [11:0] a, input logic [15:0] a_ext,
                       input int ncyc);
    logic [15:0] e;
    int          n;
    din4 = a;
    vin4 = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      tick;
      n = (k < 2) ? 0 : ((k - 1 > 4) ? 4 : k - 1);
      e = '0;
      repeat (n) e = e + a_ext;
      check(tag, {16'h0, out4}, {16'h0, e});
      check({tag, "_valid"}, {31'h0, ov4}, 32'd1);
    end
  endtask

  task automatic reset4;
    rst4_n = 1'b0;
    vin4   = 1'b0;
    tick;
    rst4_n = 1'b1;
  endtask

  function automatic int xs64(input int m);
    return (m % 2 == 0) ? 4095 : 0;
  endfunction

  initial begin
    int y;
    int i;
    rst4_n  = 1'b0;
    din4    = '0;
    vin4    = 1'b0;
    rst64_n = 1'b0;
    din64   = '0;
    vin64   = 1'b0;

    // Reset and idle
    repeat (3) tick;
    check("rst_out",   {16'h0, out4}, 32'd0);
    check("rst_valid", {31'h0, ov4},  32'd0);
    check("rst_ready", {31'h0, rdy4}, 32'd1);
    check("rst_ur",    {31'h0, ur4},  32'd0);
    check("rst_cnt",   {29'h0, cnt4}, 32'd0);
    rst4_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      check("idle_ready", {31'h0, rdy4}, (k % 4 == 0) ? 32'd1 : 32'd0);
      tick;
      check("idle_ur",    {31'h0, ur4},  (k % 4 == 0) ? 32'd1 : 32'd0);
      check("idle_cnt",   {29'h0, cnt4}, 32'(k / 4 + 1));
      check("idle_out",   {16'h0, out4}, 32'd0);
      check("idle_valid", {31'h0, ov4},  32'd0);
    end

    // Unit step
    step4("step1", 12'd1, 16'h0001, 12);
    check("step1_cnt", {29'h0, cnt4}, 32'd3);

    // Mid-operation reset at phase 2
    tick;
    tick;
    check("pre_rst_out",   {16'h0, out4}, 32'd4);
    check("pre_rst_ready", {31'h0, rdy4}, 32'd0);
    rst4_n = 1'b0;
    tick;
    check("mrst_out",   {16'h0, out4}, 32'd0);
    check("mrst_valid", {31'h0, ov4},  32'd0);
    check("mrst_ready", {31'h0, rdy4}, 32'd1);
    check("mrst_ur",    {31'h0, ur4},  32'd0);
    check("mrst_cnt",   {29'h0, cnt4}, 32'd0);
    rst4_n = 1'b1;
    step4("step1_after_rst", 12'd1, 16'h0001, 12);

    // Signed step of -1 settles at 16'hFFFC
    reset4;
    step4("sstep", 12'hFFF, 16'hFFFF, 8);
    check("sstep_final", {16'h0, out4}, 32'h0000FFFC);

    // Underrun while holding a settled value of 20
    reset4;
    step4("step5", 12'd5, 16'h0005, 8);
    for (int k = 0; k < 8; k++) begin
      vin4 = (k != 0);
      tick;
      check("hold_out", {16'h0, out4}, 32'd20);
      check("hold_ur",  {31'h0, ur4},  (k == 0) ? 32'd1 : 32'd0);
      check("hold_cnt", {29'h0, cnt4}, 32'd1);
    end

    // Counter saturates at 7 for CNT_W=3
    reset4;
    vin4 = 1'b0;
    repeat (40) tick;
    check("sat_cnt", {29'h0, cnt4}, 32'd7);
    check("sat_out", {16'h0, out4}, 32'd0);

    // Full-scale alternating input, OSR=64, against a cascaded-boxcar model
    check("w64_rst_out", {8'h0, out64}, 32'd0);
    rst64_n = 1'b1;
    vin64   = 1'b1;
    din64   = 12'(xs64(0));
    y = 0;
    for (int k = 0; k < 1000 * 64; k++) begin
      tick;
      if (k % 64 == 0) din64 = 12'(xs64(k / 64 + 1));
      i = k - 2;
      if (i >= 0) y = y + xs64(i / 64);
      if (i >= 64) y = y - xs64((i - 64) / 64);
      check("wrap64", {8'h0, out64}, {8'h0, 24'(y)});
    end
    check("w64_valid", {31'h0, ov64},  32'd1);
    check("w64_cnt",   {24'h0, cnt64}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- 2nd-order CIC interpolator. It is the transmit-side counterpart of the 2nd-order CIC decimator in the ADC receive chain.
- It takes one low-rate sample every OSR clocks through a valid/ready handshake, runs two combs at the low rate, zero-stuffs by OSR, and runs two integrators at the full FADC rate.
- It drives the digital sigma-delta / DAC modulator path, or serves as a loopback stimulus source for the decimator.

Parameters:
- OSR, 64, interpolation ratio; must be a power of 2, at least 2.
- BIT, 12, input sample width.
- SIGNED_IN, 1, 1 = IN_DATA is two's complement and is sign-extended; 0 = unsigned and is zero-extended.
- CNT_W, 8, width of the saturating underrun counter.

Ports:
- FADC  input  1  single clock, full output rate.
- RST_SN  input  1  reset, synchronous, active-low.
- IN_DATA  input  BIT  low-rate input sample.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  high only in the phase-0 cycle; a transfer happens when IN_VALID && IN_READY.
- OUT_DATA  output  BIT+2*$clog2(OSR)  full-rate interpolated output; this is the integrator-2 register.
- OUT_VALID  output  1  high from the cycle after the first accepted sample until reset.
- UNDERRUN  output  1  one-cycle pulse when the phase-0 cycle has no valid input.
- UNDERRUN_CNT  output  CNT_W  saturating count of underruns.

Behaviour:
- Reset is synchronous and active-low. With RST_SN=0 at a FADC rising edge, every register clears: phase counter, X, X_1D, C1, C1_1D, C2, I1, I2 (OUT_DATA), OUT_VALID, UNDERRUN, UNDERRUN_CNT. A reset mid-operation discards all filter state; after it, the first cycle is phase 0.
- Working width W = BIT+2*log2(OSR). All internal arithmetic is W-bit modular two's complement. Intermediate wrap-around is intended; the final output is exact provided the true result fits in W bits.
- Phase counter PH runs 0..OSR-1, increments every cycle and wraps from OSR-1 to 0.
- IN_READY = (PH==0), driven combinationally from PH.
- Phase 0, IN_VALID=1 (accept):
  - X <= extended IN_DATA; X_1D <= X.
  - C1 <= Xnew - X; C1_1D <= C1; C2 <= C1new - C1. The comb is computed from the new value in the same edge.
  - OUT_VALID <= 1.
- Phase 0, IN_VALID=0 (underrun):
  - Treat the input as a repeat of the previous X; the combs update with Xnew = X.
  - UNDERRUN <= 1 for one cycle; UNDERRUN_CNT increments and saturates at 2^CNT_W-1.
  - OUT_VALID is unchanged.
- Zero-stuffer: U = C2 when PH==1, otherwise 0. Only the comb result from the immediately preceding phase 0 enters the integrators.
- Integrators, every cycle: I1 <= I1 + U; I2 <= I2 + I1, using the old I1.
- Latency: a sample accepted at edge t first affects OUT_DATA after edge t+2.
- DC gain is OSR: a constant input A settles to OUT_DATA = OSR*A.
- OUT_DATA is not rescaled. Downstream takes the top BIT bits or applies a shift.
- Before the first accept, OUT_DATA stays 0 and OUT_VALID=0.

Decomposition:
- Shared package holds:
  - CIC width function cic_w(BIT, OSR) = BIT+2*$clog2(OSR), shared with the decimator;
  - CIC_ORDER = 2;
  - an elaboration check that OSR is a power of 2.
- One natural sub-module: cic_integrator2 (two cascaded W-bit accumulators, synchronous active-low clear).
- Combs, phase counter and handshake stay in the top level.

Test Plan:
- Reset / idle: hold RST_SN=0 for 3 cycles, release, no valid input.
  -> OUT_DATA=0, OUT_VALID=0, IN_READY high at cycles 0, OSR, 2*OSR, ...; UNDERRUN pulses at each phase 0; UNDERRUN_CNT counts 1, 2, 3, ...
- Step (OSR=4, BIT=12): present IN_DATA=1 with IN_VALID=1 continuously.
  -> after edges t+2..t+5, OUT_DATA = 1, 2, 3, 4, then holds 4; OUT_VALID=1 from t+1.
- Signed step (OSR=4): IN_DATA=12'hFFF (-1), SIGNED_IN=1.
  -> OUT_DATA ramps -1, -2, -3, then settles at -4, i.e. 16'hFFFC with W=16.
- Underrun hold: input A=5, then drop IN_VALID for one phase-0 cycle.
  -> UNDERRUN pulses once, UNDERRUN_CNT=1, OUT_DATA stays 20 (OSR=4) with no glitch.
- Full-scale wrap (OSR=64, SIGNED_IN=0): input alternates 4095 and 0 per sample.
  -> OUT_DATA matches a golden model computed with W=24 modular arithmetic bit-exactly over 1000 samples.
- Mid-operation reset: assert RST_SN=0 for one cycle while PH=2 and OUT_DATA is non-zero.
  -> next cycle all state is 0, PH=0, IN_READY=1; a subsequent step response is identical to the fresh-reset case; UNDERRUN_CNT is cleared.
